// File: rtl/cim_core_ctrl_if.sv
// Stream and Core-pin bundle for cim_core_ctrl; master = controller side, slave = DMA/buffers + Core.
interface cim_core_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [7:0]        n_act;
    logic              w_valid;
    logic              w_ready;
    logic [287:0]      w_data;
    logic              a_valid;
    logic              a_ready;
    logic [255:0]      a_data;
    logic              STDW;
    logic              STDR;
    logic [ADDR_W-1:0] STD_A;
    logic [287:0]      weight_in;
    logic [255:0]      act_in1;
    logic [255:0]      act_in2;
    logic [255:0]      act_in3;
    logic              slide_en;
    logic [287:0]      weight_out;
    logic              psum_valid;
    logic              busy;
    logic              done;
    logic              wt_err;

    modport master (
        input  start, n_act, w_valid, w_data, a_valid, a_data, weight_out,
        output w_ready, a_ready, STDW, STDR, STD_A, weight_in,
               act_in1, act_in2, act_in3, slide_en, psum_valid, busy, done, wt_err
    );

    modport slave (
        output start, n_act, w_valid, w_data, a_valid, a_data, weight_out,
        input  w_ready, a_ready, STDW, STDR, STD_A, weight_in,
               act_in1, act_in2, act_in3, slide_en, psum_valid, busy, done, wt_err
    );
endinterface

// File: rtl/cim_core_ctrl.sv
// Job sequencer for one Core CIM macro: STD-port weight load, activation window streaming, PSUM tagging.
// Define CIM_CTRL_READBACK_EN to add the VERIFY readback pass (checksum compare, wt_err).
module cim_core_ctrl #(
    parameter int N_ROWS   = 64,
    parameter int ADDR_W   = 6,
    parameter int PSUM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cim_core_ctrl_if.master bus
);

    localparam int LAT_W = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
`ifdef CIM_CTRL_READBACK_EN
        S_VERIFY,
`endif
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_w_ready;
    logic                w_a_ready;
    logic                w_w_acc;
    logic                w_a_acc;
    logic                w_last_row;
    logic [7:0]          r_remain;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_std_a;
    logic                r_primed;
    logic [LAT_W-1:0]    r_drain_cnt;
    logic                r_stdw;
    logic                r_slide_en;
    logic [287:0]        r_weight_in;
    logic [255:0]        r_act1;
    logic [255:0]        r_act2;
    logic [255:0]        r_act3;
    logic [PSUM_LAT-1:0] r_psum_sr;

`ifdef CIM_CTRL_READBACK_EN
    localparam int VCNT_W = $clog2(N_ROWS + 2);
    logic [VCNT_W-1:0] r_vcnt;
    logic              r_stdr;
    logic              r_rd_d1;
    logic              r_cmp;
    logic              r_wt_err;
    logic [287:0]      r_chk_w;
    logic [287:0]      r_chk_r;
    logic              w_verify_end;

    // Reads occupy the first N_ROWS cycles; the last two let the one-cycle readback drain.
    assign w_verify_end = (r_vcnt == VCNT_W'(N_ROWS + 1));
`endif

    assign w_last_row = (r_addr == ADDR_W'(N_ROWS - 1));
    assign w_w_acc    = bus.w_valid & w_w_ready;
    assign w_a_acc    = bus.a_valid & w_a_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_w_ready = 1'b0;
        w_a_ready = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD_W;
            S_LOAD_W: begin
                w_w_ready = 1'b1;
                if (bus.w_valid && w_last_row)
`ifdef CIM_CTRL_READBACK_EN
                    w_next = S_VERIFY;
`else
                    w_next = (r_remain == '0) ? S_FIN : S_PRIME;
`endif
            end
`ifdef CIM_CTRL_READBACK_EN
            S_VERIFY: if (w_verify_end) w_next = (r_remain == '0) ? S_FIN : S_PRIME;
`endif
            S_PRIME: begin
                w_a_ready = 1'b1;
                if (bus.a_valid && r_primed) w_next = S_STREAM;
            end
            S_STREAM: begin
                w_a_ready = 1'b1;
                if (bus.a_valid && (r_remain == 8'd1)) w_next = S_DRAIN;
            end
            S_DRAIN: if (r_drain_cnt == LAT_W'(PSUM_LAT - 1)) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remain    <= '0;
            r_addr      <= '0;
            r_std_a     <= '0;
            r_primed    <= 1'b0;
            r_drain_cnt <= '0;
            r_stdw      <= 1'b0;
            r_slide_en  <= 1'b0;
            r_weight_in <= '0;
            r_act1      <= '0;
            r_act2      <= '0;
            r_act3      <= '0;
            r_psum_sr   <= '0;
        end else begin
            r_stdw      <= w_w_acc;
            r_slide_en  <= w_a_acc && (r_state == S_STREAM);
            r_psum_sr   <= (r_psum_sr << 1) | PSUM_LAT'(r_slide_en);
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + LAT_W'(1) : '0;
            if ((r_state == S_IDLE) && bus.start) begin
                r_remain <= bus.n_act;
                r_addr   <= '0;
                r_primed <= 1'b0;
            end
            if (w_w_acc) begin
                r_weight_in <= bus.w_data;
                r_std_a     <= r_addr;
                r_addr      <= r_addr + ADDR_W'(1);
            end
            if (w_a_acc) begin
                r_act1 <= bus.a_data;
                r_act2 <= r_act1;
                r_act3 <= r_act2;
                if (r_state == S_PRIME) r_primed <= 1'b1;
                else                    r_remain <= r_remain - 8'd1;
            end
`ifdef CIM_CTRL_READBACK_EN
            if ((r_state == S_VERIFY) && (r_vcnt < VCNT_W'(N_ROWS)))
                r_std_a <= r_vcnt[ADDR_W-1:0];
`endif
        end
    end

`ifdef CIM_CTRL_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcnt   <= '0;
            r_stdr   <= 1'b0;
            r_rd_d1  <= 1'b0;
            r_cmp    <= 1'b0;
            r_wt_err <= 1'b0;
            r_chk_w  <= '0;
            r_chk_r  <= '0;
        end else begin
            r_vcnt  <= (r_state == S_VERIFY) ? r_vcnt + VCNT_W'(1) : '0;
            r_stdr  <= (r_state == S_VERIFY) && (r_vcnt < VCNT_W'(N_ROWS));
            r_rd_d1 <= r_stdr;
            r_cmp   <= (r_state == S_VERIFY) && w_verify_end;
            if ((r_state == S_IDLE) && bus.start) begin
                r_chk_w  <= '0;
                r_chk_r  <= '0;
                r_wt_err <= 1'b0;
            end else begin
                if (w_w_acc) r_chk_w <= r_chk_w ^ bus.w_data;
                if (r_rd_d1) r_chk_r <= r_chk_r ^ bus.weight_out;
                if (r_cmp && (r_chk_w != r_chk_r)) r_wt_err <= 1'b1;
            end
        end
    end

    assign bus.STDR   = r_stdr;
    assign bus.wt_err = r_wt_err;
`else
    logic w_unused_rb;
    assign w_unused_rb = ^bus.weight_out;
    assign bus.STDR    = 1'b0;
    assign bus.wt_err  = 1'b0;
`endif

    assign bus.w_ready    = w_w_ready;
    assign bus.a_ready    = w_a_ready;
    assign bus.STDW       = r_stdw;
    assign bus.STD_A      = r_std_a;
    assign bus.weight_in  = r_weight_in;
    assign bus.act_in1    = r_act1;
    assign bus.act_in2    = r_act2;
    assign bus.act_in3    = r_act3;
    assign bus.slide_en   = r_slide_en;
    assign bus.psum_valid = r_psum_sr[PSUM_LAT-1];
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_FIN);

endmodule

// File: doc/cim_core_ctrl.md
# cim_core_ctrl

Sequencer for one `Core` CIM macro. It takes a 64-row weight stream and writes it through the core's STD port with `STDW`/`STD_A`. It then primes and streams 256-bit activation vectors into the `act_in1..3` sliding window with `slide_en`, and flags each valid `PSUM`. It sits between the tile-level DMA/buffer streams and `Core`, and replaces the hand-driven pin sequences used in bring-up.

## Interface
Parameters:
- `N_ROWS`, 64: weight rows written per load; `STD_A` spans 0..N_ROWS-1.
- `ADDR_W`, 6: `STD_A` width.
- `PSUM_LAT`, 2: cycles from a `slide_en` cycle to valid `PSUM`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a job; ignored unless `busy`=0.
- `n_act`  in  8  compute vectors for this job; sampled on the accepted `start`.
- `w_valid`  in  1  weight word valid.
- `w_ready`  out  1  weight word accepted when `w_valid & w_ready`.
- `w_data`  in  288  weight row.
- `a_valid`  in  1  activation vector valid.
- `a_ready`  out  1  activation accepted when `a_valid & a_ready`.
- `a_data`  in  256  activation vector.
- `STDW`, `STDR`  out  1  core STD write/read strobes.
- `STD_A`  out  ADDR_W  core STD address.
- `weight_in`  out  288  core weight bus.
- `act_in1`, `act_in2`, `act_in3`  out  256  core activation window.
- `slide_en`  out  1  core window advance.
- `weight_out`  in  288  core readback bus, used only with the macro.
- `psum_valid`  out  1  `PSUM` is valid this cycle.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at job end.
- `wt_err`  out  1  readback mismatch, sticky until next `start`; only with the macro.

## Operation
- Reset value of every output is 0; state is IDLE.
- States: IDLE → LOAD_W → [VERIFY] → PRIME → STREAM → DRAIN → FIN → IDLE.
- IDLE:
  - `w_ready`=`a_ready`=0.
  - An accepted `start` latches `n_act`, clears the address counter, sets `busy`, and enters LOAD_W.
- LOAD_W:
  - `w_ready`=1.
  - Each accepted word registers `weight_in`<=`w_data`, `STD_A`<=counter, `STDW`<=1 for that single cycle. The counter then increments.
  - No accept gives `STDW`=0, with `weight_in`/`STD_A` held.
  - After row N_ROWS-1 is accepted, go to VERIFY if the macro is defined, else PRIME.
- PRIME:
  - `a_ready`=1.
  - Each accept shifts the window: `act_in3`<=`act_in2`, `act_in2`<=`act_in1`, `act_in1`<=`a_data`. `slide_en` stays 0.
  - After 2 accepts, go to STREAM. If `n_act`=0, skip PRIME/STREAM/DRAIN and go straight to FIN.
- STREAM:
  - `a_ready`=1.
  - Each accept performs the same shift with `slide_en`=1 registered alongside it, and decrements the remaining count.
  - `a_valid`=0 stalls the stream: `slide_en`=0 and the window is held.
  - After the `n_act`-th accept, go to DRAIN.
- DRAIN: waits PSUM_LAT cycles with `a_ready`=0.
- FIN: `done`=1 for one cycle, `busy`=0 on return to IDLE.
- `psum_valid` is the `slide_en` output delayed PSUM_LAT cycles through a shift register. It keeps running through DRAIN, so exactly `n_act` pulses occur per job.

## Timing
- All core-facing outputs are registered. `STDW`/`STD_A`/`weight_in` appear the cycle after the accepting edge.
- Minimum load is N_ROWS cycles; back-to-back `w_valid` gives one row per cycle.
- Minimum job length, no stalls, macro off: 1 + N_ROWS + 2 + n_act + PSUM_LAT + 1 cycles from `start`.
- `start` during `busy` is ignored with no side effects.
- `STDW` and `STDR` are never high together. `slide_en` is never high outside STREAM.
- `rst_n` low mid-job asynchronously clears all state and outputs. The pipeline is flushed and no `done` is issued.

## Configuration
- `CIM_CTRL_READBACK_EN` defined:
  - LOAD_W XOR-folds every accepted `w_data` into a 288-bit checksum.
  - VERIFY drives `STDR`=1 with `STD_A`=0..N_ROWS-1, one per cycle. `weight_out` is sampled one cycle after each read and folded into a second checksum.
  - One cycle after the last sample, the checksums are compared; mismatch sets `wt_err`. The job continues to PRIME regardless.
  - VERIFY adds N_ROWS+2 cycles.
- Not defined: no VERIFY state, no checksums, `STDR` and `wt_err` tied 0, and `weight_out` unused.

## Test plan
- Reset, `start`, `n_act`=3, 64 rows of all-0x1 nibbles streamed back-to-back → `STDW` high 64 consecutive cycles, `STD_A` 0..63, 3 `slide_en` pulses, 3 `psum_valid` pulses each 2 cycles after their `slide_en`, `done` at cycle 72.
- `w_valid` toggled every other cycle → `STDW` only on accepted cycles, `STD_A` contiguous with no skips, 64 writes total.
- `a_valid` dropped 5 cycles mid-STREAM → `slide_en`=0 and `act_in1..3` held during the gap; total `psum_valid` count still equals `n_act`.
- `n_act`=0 → no `a_ready`, `slide_en`, or `psum_valid`; `done` right after LOAD_W (plus VERIFY if the macro is on).
- `rst_n` pulsed low at row 30, then a new job → all outputs 0 during reset, new job starts at `STD_A`=0, no stray `done`.
- Macro on, core model corrupting row 35 readback → 64 `STDR` cycles, `wt_err`=1, job still completes; with clean readback `wt_err`=0.
